// File: rtl/ok_host_endpoint_if.sv
// Host command decoder driving WireIn (held, published on UPDATE) and TriggerIn
// (single-cycle pulse) endpoints. All outputs are registered on okClk.
module ok_host_endpoint_if #(
  parameter int         WI_COUNT = 1,
  parameter logic [7:0] WI_BASE  = 8'h00,
  parameter int         TI_COUNT = 1,
  parameter logic [7:0] TI_BASE  = 8'h41
) (
  input  logic                    okClk,
  input  logic                    reset_n,
  input  logic                    host_valid,
  input  logic [2:0]              host_cmd,
  input  logic [7:0]              host_addr,
  input  logic [31:0]             host_wdata,
  output logic                    host_ack,
  output logic                    host_err,
  output logic [31:0]             host_rdata,
  output logic [32*WI_COUNT-1:0]  ep_wirein,
  output logic [32*TI_COUNT-1:0]  ep_trigger
);

  typedef enum logic [2:0] {
    CMD_NOP         = 3'd0,
    CMD_WRITE_WI    = 3'd1,
    CMD_UPDATE_WI   = 3'd2,
    CMD_ACTIVATE_TI = 3'd3,
    CMD_READ_WI     = 3'd4
  } cmd_e;

  localparam logic [8:0] WI_LIMIT = 9'(WI_COUNT);
  localparam logic [8:0] TI_LIMIT = 9'(TI_COUNT);

  // Handshake: a command is taken on every edge where host_valid=1 (no stall);
  // every non-NOP command answers with host_ack (plus host_err on a miss or an
  // unknown opcode) exactly one cycle later, with host_rdata valid alongside.

  logic [32*WI_COUNT-1:0] shadow_q,  shadow_d;
  logic [32*WI_COUNT-1:0] wirein_q,  wirein_d;
  logic [32*TI_COUNT-1:0] trigger_q, trigger_d;
  logic                   ack_q,     ack_d;
  logic                   err_q,     err_d;
  logic [31:0]            rdata_q,   rdata_d;

  logic [8:0] wi_off;
  logic [8:0] ti_off;
  logic       wi_hit;
  logic       ti_hit;

  // 9-bit offsets so an address below the base cannot wrap into range.
  always_comb begin
    wi_off = {1'b0, host_addr} - {1'b0, WI_BASE};
    ti_off = {1'b0, host_addr} - {1'b0, TI_BASE};
    wi_hit = (host_addr >= WI_BASE) && (wi_off < WI_LIMIT);
    ti_hit = (host_addr >= TI_BASE) && (ti_off < TI_LIMIT);
  end

  always_comb begin
    shadow_d  = shadow_q;
    wirein_d  = wirein_q;
    trigger_d = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    if (host_valid) begin
      case (host_cmd)
        CMD_NOP: ;
        CMD_WRITE_WI: begin
          ack_d = 1'b1;
          if (wi_hit) begin
            for (int i = 0; i < WI_COUNT; i++) begin
              if (wi_off == 9'(i)) shadow_d[32*i +: 32] = host_wdata;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_UPDATE_WI: begin
          ack_d    = 1'b1;
          wirein_d = shadow_q;
        end
        CMD_ACTIVATE_TI: begin
          ack_d = 1'b1;
          if (ti_hit) begin
            for (int i = 0; i < TI_COUNT; i++) begin
              if (ti_off == 9'(i)) trigger_d[32*i +: 32] = host_wdata;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_READ_WI: begin
          ack_d = 1'b1;
          if (wi_hit) begin
            for (int i = 0; i < WI_COUNT; i++) begin
              if (wi_off == 9'(i)) rdata_d = shadow_q[32*i +: 32];
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      wirein_q  <= '0;
      trigger_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      wirein_q  <= wirein_d;
      trigger_q <= trigger_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign host_ack   = ack_q;
  assign host_err   = err_q;
  assign host_rdata = rdata_q;
  assign ep_wirein  = wirein_q;
  assign ep_trigger = trigger_q;

endmodule

// File: tb/tb_ok_host_endpoint_if.sv
// Bench for ok_host_endpoint_if: directed scenarios then randomized commands,
// checked against a command-level model of shadow/published endpoint values.
module tb_ok_host_endpoint_if;

  localparam int WI_N = 4;
  localparam int WI_B = 8'h00;
  localparam int TI_N = 2;
  localparam int TI_B = 8'h41;

  logic                 clk;
  logic                 reset_n;
  logic                 host_valid;
  logic [2:0]           host_cmd;
  logic [7:0]           host_addr;
  logic [31:0]          host_wdata;
  logic                 host_ack;
  logic                 host_err;
  logic [31:0]          host_rdata;
  logic [32*WI_N-1:0]   ep_wirein;
  logic [32*TI_N-1:0]   ep_trigger;

  int vectors;
  int miscompares;

  logic [31:0] shadow_m [WI_N];
  logic [31:0] pub_m    [WI_N];

  ok_host_endpoint_if #(
    .WI_COUNT(WI_N),
    .WI_BASE (8'(WI_B)),
    .TI_COUNT(TI_N),
    .TI_BASE (8'(TI_B))
  ) dut (
    .okClk     (clk),
    .reset_n   (reset_n),
    .host_valid(host_valid),
    .host_cmd  (host_cmd),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_err  (host_err),
    .host_rdata(host_rdata),
    .ep_wirein (ep_wirein),
    .ep_trigger(ep_trigger)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit wi_hit(input logic [7:0] a);
    return (int'(a) >= WI_B) && (int'(a) < WI_B + WI_N);
  endfunction

  function automatic bit ti_hit(input logic [7:0] a);
    return (int'(a) >= TI_B) && (int'(a) < TI_B + TI_N);
  endfunction

  function automatic logic [32*WI_N-1:0] published();
    logic [32*WI_N-1:0] r;
    for (int i = 0; i < WI_N; i++) r[32*i +: 32] = pub_m[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One host cycle: drive, predict, then check the registered response.
  task automatic step(input string tag, input logic v, input logic [2:0] c,
                      input logic [7:0] a, input logic [31:0] d);
    logic               e_ack;
    logic               e_err;
    logic [31:0]        e_rd;
    logic [32*TI_N-1:0] e_tr;
    @(negedge clk);
    reset_n    = 1'b1;
    host_valid = v;
    host_cmd   = c;
    host_addr  = a;
    host_wdata = d;
    e_ack = v && (c != 3'd0);
    e_err = v && ((c >= 3'd5) ||
                  ((c == 3'd1 || c == 3'd4) && !wi_hit(a)) ||
                  ((c == 3'd3) && !ti_hit(a)));
    e_rd  = '0;
    e_tr  = '0;
    if (v && c == 3'd4 && wi_hit(a)) e_rd = shadow_m[int'(a) - WI_B];
    if (v && c == 3'd3 && ti_hit(a)) e_tr[32*(int'(a) - TI_B) +: 32] = d;
    if (v && c == 3'd2) pub_m = shadow_m;
    if (v && c == 3'd1 && wi_hit(a)) shadow_m[int'(a) - WI_B] = d;
    @(posedge clk);
    #1;
    check({tag, ".ack"},     128'(host_ack),   128'(e_ack));
    check({tag, ".err"},     128'(host_err),   128'(e_err));
    check({tag, ".rdata"},   128'(host_rdata), 128'(e_rd));
    check({tag, ".trigger"}, 128'(ep_trigger), 128'(e_tr));
    check({tag, ".wirein"},  128'(ep_wirein),  128'(published()));
  endtask

  // Reset with a command presented in the same cycle; the command must be dropped.
  task automatic do_reset(input string tag, input logic [2:0] c,
                          input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reset_n    = 1'b0;
    host_valid = 1'b1;
    host_cmd   = c;
    host_addr  = a;
    host_wdata = d;
    for (int i = 0; i < WI_N; i++) begin
      shadow_m[i] = '0;
      pub_m[i]    = '0;
    end
    @(posedge clk);
    #1;
    check({tag, ".ack"},     128'(host_ack),   128'(0));
    check({tag, ".err"},     128'(host_err),   128'(0));
    check({tag, ".rdata"},   128'(host_rdata), 128'(0));
    check({tag, ".trigger"}, 128'(ep_trigger), 128'(0));
    check({tag, ".wirein"},  128'(ep_wirein),  128'(0));
  endtask

  initial begin
    logic [7:0] a;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    host_valid  = 1'b0;
    host_cmd    = '0;
    host_addr   = '0;
    host_wdata  = '0;
    for (int i = 0; i < WI_N; i++) begin
      shadow_m[i] = '0;
      pub_m[i]    = '0;
    end

    do_reset("rst0", 3'd3, 8'h41, 32'hFFFF_FFFF);
    do_reset("rst1", 3'd1, 8'h00, 32'h1111_1111);
    step("rd_after_rst", 1'b1, 3'd4, 8'h00, 32'h0);

    step("wr5",        1'b1, 3'd1, 8'h00, 32'h0000_0005);
    step("idle0",      1'b0, 3'd1, 8'h00, 32'h0);
    step("upd5",       1'b1, 3'd2, 8'h99, 32'h0);
    step("nop",        1'b1, 3'd0, 8'h00, 32'h0);

    step("ti80",       1'b1, 3'd3, 8'h41, 32'h0000_0080);
    step("ti80_off",   1'b0, 3'd0, 8'h00, 32'h0);
    step("ti_b2b_a",   1'b1, 3'd3, 8'h41, 32'h0081_8A2B);
    step("ti_b2b_b",   1'b1, 3'd3, 8'h41, 32'h0000_8005);
    step("ti_b2b_off", 1'b0, 3'd0, 8'h00, 32'h0);
    step("ti_idx1",    1'b1, 3'd3, 8'h42, 32'hA5A5_0001);
    step("ti_mask0",   1'b1, 3'd3, 8'h41, 32'h0);
    step("ti_miss40",  1'b1, 3'd3, 8'h40, 32'hFFFF_FFFF);
    step("ti_miss43",  1'b1, 3'd3, 8'h43, 32'hFFFF_FFFF);

    step("wr_miss07",  1'b1, 3'd1, 8'h07, 32'hBAD0_BAD0);
    step("rd_miss07",  1'b1, 3'd4, 8'h07, 32'h0);
    step("rd_keep",    1'b1, 3'd4, 8'h00, 32'h0);
    step("cmd5",       1'b1, 3'd5, 8'h00, 32'h1);
    step("cmd6",       1'b1, 3'd6, 8'h41, 32'h1);
    step("cmd7",       1'b1, 3'd7, 8'h02, 32'h1);

    do_reset("rst2", 3'd2, 8'h00, 32'h0);
    step("wr_dead",    1'b1, 3'd1, 8'h00, 32'hDEAD_BEEF);
    step("rd_dead",    1'b1, 3'd4, 8'h00, 32'h0);
    step("wr_top",     1'b1, 3'd1, 8'h03, 32'h3333_CAFE);
    step("rd_top",     1'b1, 3'd4, 8'h03, 32'h0);

    step("wr1234",     1'b1, 3'd1, 8'h00, 32'h0000_1234);
    step("upd1234",    1'b1, 3'd2, 8'h00, 32'h0);
    step("ti_pre_rst", 1'b1, 3'd3, 8'h41, 32'hFFFF_0000);
    do_reset("rst_mid",  3'd3, 8'h41, 32'h0000_FFFF);
    step("rd_cleared", 1'b1, 3'd4, 8'h00, 32'h0);
    step("upd_zero",   1'b1, 3'd2, 8'h00, 32'h0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 7));
        1:       a = 8'($urandom_range(8'h3E, 8'h45));
        2:       a = 8'($urandom);
        default: a = 8'($urandom_range(0, WI_N - 1));
      endcase
      if ($urandom_range(0, 59) == 0)
        do_reset("rand_rst", 3'($urandom_range(0, 7)), a, $urandom);
      else
        step("rand", 1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), a, $urandom);
    end

    @(negedge clk);
    host_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
